fmul_sched: RTL and testbench

FMUL_SCHED -- requirements
Module: fmul_sched

---
 rtl/fmul_sched.sv | 201 ++++++++++++++++++++
 tb/tb_fmul_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_sched.sv
// Two-port scheduler sharing one flush-to-zero fmul: credit-gated round-robin issue,
// a tag pipeline that tracks each product's owner, and a per-port FWFT result FIFO.

module fmul (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);
    logic        zero_q, zero_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [47:0] prod_q, prod_d;
    logic [31:0] c_q, c_d;
    logic [9:0]  exp_n;
    logic [22:0] man_n;

    always_comb begin
        zero_d = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
        sign_d = a[31] ^ b[31];
        // Two's-complement biased exponent sum; may go negative or above 254.
        exp_d  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        prod_d = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};

        exp_n  = exp_q + {9'd0, prod_q[47]};
        man_n  = prod_q[47] ? prod_q[46:24] : prod_q[45:23];
        if (zero_q)
            c_d = 32'd0;
        else if ($signed(exp_n) <= 10'sd0)
            c_d = {sign_q, 31'd0};
        else if ($signed(exp_n) >= 10'sd255)
            c_d = {sign_q, 8'hff, 23'd0};
        else
            c_d = {sign_q, exp_n[7:0], man_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            sign_q <= 1'b0;
            exp_q  <= 10'd0;
            prod_q <= 48'd0;
            c_q    <= 32'd0;
        end else begin
            zero_q <= zero_d;
            sign_q <= sign_d;
            exp_q  <= exp_d;
            prod_q <= prod_d;
            c_q    <= c_d;
        end
    end

    assign c = c_q;
endmodule

module fmul_sched #(
    parameter int LAT   = 2,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_c,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_c,
    input  logic        resp1_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    elig;
    logic          grant;
    logic          gid;
    logic [1:0]    grant_k;
    logic [1:0]    pop;
    logic [1:0]    wr_en;
    logic [1:0]    resp_ready_k;
    logic [31:0]   mul_a, mul_b, mul_c;

    logic          prio_q, prio_d;
    logic          tag_v_q  [LAT];
    logic          tag_v_d  [LAT];
    logic          tag_id_q [LAT];
    logic          tag_id_d [LAT];
    logic [CW-1:0] cred_q [2];
    logic [CW-1:0] cred_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic [PW-1:0] wp_q   [2];
    logic [PW-1:0] wp_d   [2];
    logic [PW-1:0] rp_q   [2];
    logic [PW-1:0] rp_d   [2];
    logic [31:0]   mem_q  [2][DEPTH];
    logic [31:0]   mem_d  [2][DEPTH];

    // A port may issue only while it owns a free FIFO slot; pops free credit next cycle.
    always_comb begin
        elig[0] = !rst && req0_valid && (cred_q[0] < CW'(DEPTH));
        elig[1] = !rst && req1_valid && (cred_q[1] < CW'(DEPTH));
        grant   = |elig;
        gid     = (&elig) ? prio_q : elig[1];
        grant_k = {grant && gid, grant && !gid};
        prio_d  = grant ? !gid : prio_q;
        mul_a   = 32'd0;
        mul_b   = 32'd0;
        if (grant) begin
            mul_a = gid ? req1_a : req0_a;
            mul_b = gid ? req1_b : req0_b;
        end
    end

    assign req0_ready = grant_k[0];
    assign req1_ready = grant_k[1];

    always_comb begin
        tag_v_d[0]  = grant;
        tag_id_d[0] = gid;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_comb begin
        resp_ready_k = {resp1_ready, resp0_ready};
        wr_en[0]     = tag_v_q[LAT-1] && !tag_id_q[LAT-1];
        wr_en[1]     = tag_v_q[LAT-1] && tag_id_q[LAT-1];
        mem_d        = mem_q;
        for (int k = 0; k < 2; k++) begin
            pop[k]  = resp_ready_k[k] && (cnt_q[k] != '0);
            wp_d[k] = wp_q[k];
            rp_d[k] = rp_q[k];
            if (wr_en[k]) begin
                mem_d[k][wp_q[k]] = mul_c;
                wp_d[k] = (wp_q[k] == PW'(DEPTH - 1)) ? '0 : wp_q[k] + PW'(1);
            end
            if (pop[k])
                rp_d[k] = (rp_q[k] == PW'(DEPTH - 1)) ? '0 : rp_q[k] + PW'(1);
            cnt_d[k]  = cnt_q[k] + CW'(wr_en[k]) - CW'(pop[k]);
            cred_d[k] = cred_q[k] + CW'(grant_k[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                cred_q[k] <= '0;
                cnt_q[k]  <= '0;
                wp_q[k]   <= '0;
                rp_q[k]   <= '0;
            end
        end else begin
            prio_q   <= prio_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            cred_q   <= cred_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign resp0_valid = (cnt_q[0] != '0);
    assign resp1_valid = (cnt_q[1] != '0);
    assign resp0_c     = resp0_valid ? mem_q[0][rp_q[0]] : 32'd0;
    assign resp1_c     = resp1_valid ? mem_q[1][rp_q[1]] : 32'd0;

    fmul u_fmul (
        .clk (clk),
        .rst (rst),
        .a   (mul_a),
        .b   (mul_b),
        .c   (mul_c)
    );

    for (genvar k = 0; k < 2; k++) begin : g_chk
        a_no_overflow : assert property (@(posedge clk) disable iff (rst)
            !(wr_en[k] && (cnt_q[k] == CW'(DEPTH))));
        a_cred_bound : assert property (@(posedge clk) disable iff (rst)
            cred_q[k] <= CW'(DEPTH));
    end
endmodule

// File: tb/tb_fmul_sched.sv
// Scoreboard bench for fmul_sched: accepted requests push a reference product,
// popped responses are compared in order, plus directed latency/arbitration/reset checks.

module tb_fmul_sched;
  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_c, resp1_c;
  logic        resp0_ready, resp1_ready;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fmul_sched #(.LAT(2), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp0_c     (resp0_c),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_c     (resp1_c),
    .resp1_ready (resp1_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // reference: truncating multiply, zero-exponent operands flush to +0, exponent saturates
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    logic        s;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return 32'd0;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, e[7:0], m};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < max_cyc) begin
      step();
      @(negedge clk);
      n++;
    end
    check_eq("drain_q0", 32'(exp_q0.size()), 32'd0);
    check_eq("drain_q1", 32'(exp_q1.size()), 32'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) exp_q0.push_back(fmul_model(req0_a, req0_b));
      if (req1_valid && req1_ready) exp_q1.push_back(fmul_model(req1_a, req1_b));
      if (resp0_valid && resp0_ready) begin
        if (exp_q0.size() == 0) check_eq("resp0_extra", {31'd0, resp0_valid}, 32'd0);
        else check_eq("resp0_data", resp0_c, exp_q0.pop_front());
      end
      if (resp1_valid && resp1_ready) begin
        if (exp_q1.size() == 0) check_eq("resp1_extra", {31'd0, resp1_valid}, 32'd0);
        else check_eq("resp1_data", resp1_c, exp_q1.pop_front());
      end
    end
  end

  logic [31:0] t4_a[3];
  logic [31:0] t4_b[3];
  int          k;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h3f800000; req0_b = 32'h3f800000;
    req1_a = 32'h3f800000; req1_b = 32'h3f800000;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // reset state, with requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req0_ready", req0_ready, 32'd0);
    check_eq("rst_req1_ready", req1_ready, 32'd0);
    check_eq("rst_resp0_valid", resp0_valid, 32'd0);
    check_eq("rst_resp1_valid", resp1_valid, 32'd0);
    check_eq("rst_resp0_c", resp0_c, 32'd0);
    check_eq("rst_resp1_c", resp1_c, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    rst = 1'b0;

    // latency: 2.0 x 3.0 accepted in N, visible in N+3
    step();
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
    @(negedge clk);
    check_eq("t1_ready", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_n1_valid", resp0_valid, 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_n2_valid", resp0_valid, 32'd0);
    step();
    @(negedge clk);
    check_eq("t1_n3_valid", resp0_valid, 32'd1);
    check_eq("t1_n3_data", resp0_c, 32'h40c00000);
    step();
    resp0_ready = 1'b1;
    @(negedge clk);
    step();
    check_eq("t1_empty", resp0_valid, 32'd0);

    // zero flush then -1.5 x 2.0, back to back
    req0_valid = 1'b1; req0_a = 32'h00000000; req0_b = 32'h3f800000;
    @(negedge clk);
    check_eq("t2_ready_a", req0_ready, 32'd1);
    step();
    req0_a = 32'hbfc00000; req0_b = 32'h40000000;
    @(negedge clk);
    check_eq("t2_ready_b", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    @(negedge clk);
    check_eq("t2_n3_valid", resp0_valid, 32'd1);
    check_eq("t2_n3_data", resp0_c, 32'h00000000);
    step();
    @(negedge clk);
    check_eq("t2_n4_valid", resp0_valid, 32'd1);
    check_eq("t2_n4_data", resp0_c, 32'hc0400000);
    drain(10);

    // both ports saturated after reset: grants alternate starting at port 0
    pulse_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      @(negedge clk);
      check_eq("t3_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(20);

    // port 1 credit stall: two accepted, third waits for a pop
    resp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t4_a[i] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      t4_b[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    end
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin
      step();
      req1_valid = 1'b1; req1_a = t4_a[k]; req1_b = t4_b[k];
      @(negedge clk);
      if (req1_ready) k++;
    end
    check_eq("t4_two_acc", 32'(k), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      req1_a = t4_a[2]; req1_b = t4_b[2];
      @(negedge clk);
      check_eq("t4_stall", req1_ready, 32'd0);
    end
    check_eq("t4_resp_valid", resp1_valid, 32'd1);
    step();
    resp1_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_pop_cycle", req1_ready, 32'd0);
    step();
    resp1_ready = 1'b0;
    @(negedge clk);
    check_eq("t4_after_pop", req1_ready, 32'd1);
    step();
    req1_valid = 1'b0; resp1_ready = 1'b1;
    drain(20);

    // reset with two products in flight
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    step();
    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
    @(negedge clk);
    check_eq("t5_acc0", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40400000;
    @(negedge clk);
    check_eq("t5_acc1", req1_ready, 32'd1);
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check_eq("t5_no_resp0", resp0_valid, 32'd0);
      check_eq("t5_no_resp1", resp1_valid, 32'd0);
    end
    // credits back at zero: each port takes exactly two before stalling
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      @(negedge clk);
      check_eq("t5_grant", {30'd0, req1_ready, req0_ready},
               (i >= 4) ? 32'd0 : ((i % 2 == 0) ? 32'd1 : 32'd2));
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
